// File: rtl/note_mixer_pwm.sv
// Three-voice envelope mixer: key-gated attack/sustain/release levels, summed per note and
// rendered as a registered PWM stream for an external RC filter.
module note_mixer_pwm #(
    parameter int unsigned clock_frequency      = 12000000,
    parameter int unsigned pwm_width            = 8,
    parameter int unsigned envelope_step_cycles = 12000,
    parameter int unsigned envelope_max         = 85,
    parameter int unsigned attack_step          = 5,
    parameter int unsigned release_step         = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] note,
    input  logic [2:0] key,
    output logic [2:0] active,
    output logic       pwm_out
);

    localparam int unsigned unused_clock_frequency = clock_frequency;
    localparam int unsigned tick_width = $clog2(envelope_step_cycles);

    localparam logic [pwm_width-1:0]  level_max = pwm_width'(envelope_max);
    localparam logic [pwm_width-1:0]  att_inc   = pwm_width'(attack_step);
    localparam logic [pwm_width-1:0]  rel_dec   = pwm_width'(release_step);
    localparam logic [tick_width-1:0] tick_last = tick_width'(envelope_step_cycles - 1);

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} state_e;

    logic [2:0]            key_meta;
    logic [2:0]            key_s;
    logic [tick_width-1:0] tick_cnt_q;
    logic                  tick;
    state_e                state_q [3];
    logic [pwm_width-1:0]  level_q [3];
    logic [pwm_width-1:0]  sum;
    logic [pwm_width-1:0]  pwm_cnt_q;
    logic [pwm_width-1:0]  duty_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= '0;
            key_s    <= '0;
        end else begin
            key_meta <= key;
            key_s    <= key_meta;
        end
    end

    assign tick = (tick_cnt_q == tick_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Key-driven transitions take priority over the tick and leave the level untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StIdle;
                level_q[i] <= '0;
            end
            active <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                active[i] <= (state_q[i] != StIdle);
                unique case (state_q[i])
                    StIdle: begin
                        level_q[i] <= '0;
                        if (key_s[i]) state_q[i] <= StAttack;
                    end
                    StAttack: begin
                        if (!key_s[i]) begin
                            state_q[i] <= StRelease;
                        end else if (tick) begin
                            if (level_q[i] >= level_max - att_inc) begin
                                level_q[i] <= level_max;
                                state_q[i] <= StSustain;
                            end else begin
                                level_q[i] <= level_q[i] + att_inc;
                            end
                        end
                    end
                    StSustain: begin
                        level_q[i] <= level_max;
                        if (!key_s[i]) state_q[i] <= StRelease;
                    end
                    StRelease: begin
                        if (key_s[i]) begin
                            state_q[i] <= StAttack;
                        end else if (tick) begin
                            if (level_q[i] <= rel_dec) begin
                                level_q[i] <= '0;
                                state_q[i] <= StIdle;
                            end else begin
                                level_q[i] <= level_q[i] - rel_dec;
                            end
                        end
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

    // Sum cannot overflow because 3*envelope_max fits in pwm_width bits.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            if (note[i]) sum = sum + level_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_out   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (&pwm_cnt_q) duty_q <= sum;
            pwm_out <= (pwm_cnt_q < duty_q);
        end
    end

endmodule

// File: tb/tb_note_mixer_pwm.sv
// Bench for note_mixer_pwm: cycle-count based envelope/PWM model, per-cycle compare of
// pwm_out and active, directed scenarios plus randomized key/note traffic.
module tb_note_mixer_pwm;

    localparam int StepCycles = 4;
    localparam int EnvMax     = 85;
    localparam int AttStep    = 5;
    localparam int RelStep    = 1;
    localparam int Period     = 256;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] note = 3'b000;
    logic [2:0] key = 3'b000;
    logic [2:0] active;
    logic       pwm_out;

    int total = 0;
    int bad = 0;

    note_mixer_pwm #(
        .clock_frequency     (12000000),
        .pwm_width           (8),
        .envelope_step_cycles(StepCycles),
        .envelope_max        (EnvMax),
        .attack_step         (AttStep),
        .release_step        (RelStep)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .note   (note),
        .key    (key),
        .active (active),
        .pwm_out(pwm_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic timed_out(input string name);
        total++;
        bad++;
        $display("FAIL %s got=timeout want=event", name);
    endtask

    // Envelope model: 0=idle 1=attack 2=sustain 3=release
    int         m_state[3];
    int         m_level[3];
    int         m_km[3];
    int         m_ks[3];
    int         m_att_ticks[3];
    int         m_rel_ticks[3];
    logic [2:0] m_act;
    int         m_cyc;
    int         m_duty;
    logic       m_pwm;

    function automatic int nxt_level(input int st, input int ks, input int tk, input int lv);
        if (st == 0) return 0;
        if (st == 1 && ks != 0 && tk != 0) return (lv + AttStep > EnvMax) ? EnvMax : lv + AttStep;
        if (st == 2) return EnvMax;
        if (st == 3 && ks == 0 && tk != 0) return (lv - RelStep < 0) ? 0 : lv - RelStep;
        return lv;
    endfunction

    function automatic int nxt_state(input int st, input int ks, input int tk, input int lv);
        case (st)
            0: return (ks != 0) ? 1 : 0;
            1: begin
                if (ks == 0) return 3;
                return (tk != 0 && lv + AttStep >= EnvMax) ? 2 : 1;
            end
            2: return (ks == 0) ? 3 : 2;
            default: begin
                if (ks != 0) return 1;
                return (tk != 0 && lv - RelStep <= 0) ? 0 : 3;
            end
        endcase
    endfunction

    function automatic int is_tick(input int cyc);
        return ((cyc % StepCycles) == StepCycles - 1) ? 1 : 0;
    endfunction

    function automatic int mix(input logic [2:0] n, input int l0, input int l1, input int l2);
        return (n[0] ? l0 : 0) + (n[1] ? l1 : 0) + (n[2] ? l2 : 0);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_state[i]     <= 0;
                m_level[i]     <= 0;
                m_km[i]        <= 0;
                m_ks[i]        <= 0;
                m_att_ticks[i] <= 0;
                m_rel_ticks[i] <= 0;
            end
            m_act  <= 3'b000;
            m_cyc  <= 0;
            m_duty <= 0;
            m_pwm  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_state[i] <= nxt_state(m_state[i], m_ks[i], is_tick(m_cyc), m_level[i]);
                m_level[i] <= nxt_level(m_state[i], m_ks[i], is_tick(m_cyc), m_level[i]);
                m_act[i]   <= (m_state[i] != 0);
                m_ks[i]    <= m_km[i];
                m_km[i]    <= int'(key[i]);
                if (m_state[i] != 1 && m_ks[i] != 0 && (m_state[i] == 0 || m_state[i] == 3))
                    m_att_ticks[i] <= 0;
                else if (m_state[i] == 1 && m_ks[i] != 0 && is_tick(m_cyc) != 0)
                    m_att_ticks[i] <= m_att_ticks[i] + 1;
                if (m_state[i] != 3 && m_ks[i] == 0 && (m_state[i] == 1 || m_state[i] == 2))
                    m_rel_ticks[i] <= 0;
                else if (m_state[i] == 3 && m_ks[i] == 0 && is_tick(m_cyc) != 0)
                    m_rel_ticks[i] <= m_rel_ticks[i] + 1;
            end
            m_pwm <= ((m_cyc % Period) < m_duty);
            if ((m_cyc % Period) == Period - 1)
                m_duty <= mix(note, m_level[0], m_level[1], m_level[2]);
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clock) begin
        check("pwm_out_cycle", int'(pwm_out), int'(m_pwm));
        check("active_cycle", int'(active), int'(m_act));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic count_high(input int chg_at, input logic [2:0] chg_note, output int h);
        h = 0;
        for (int k = 0; k < Period; k++) begin
            if (k == chg_at) note = chg_note;
            @(negedge clock);
            h += int'(pwm_out);
        end
    endtask

    initial begin
        int n;
        int h;

        cycles(3);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_active", int'(active), 0);
        reset_n = 1'b1;

        // Single attack on voice 0
        note = 3'b001;
        key  = 3'b001;
        n = 0;
        while (m_state[0] != 2 && n < 500) begin @(negedge clock); n++; end
        if (n >= 500) timed_out("attack_to_sustain");
        check("attack_ticks", m_att_ticks[0], 17);
        check("sustain_level", m_level[0], 85);
        cycles(600);
        count_high(-1, note, h);
        check("duty85_high", h, 85);

        // Release, retrigger at 60, full release
        key = 3'b000;
        n = 0;
        while (!(m_state[0] == 3 && m_level[0] == 60) && n < 1000) begin @(negedge clock); n++; end
        if (n >= 1000) timed_out("release_to_60");
        key = 3'b001;
        n = 0;
        while (m_state[0] != 1 && n < 20) begin @(negedge clock); n++; end
        if (n >= 20) timed_out("retrigger");
        check("retrig_level", m_level[0], 60);
        n = 0;
        while (m_state[0] != 2 && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) timed_out("retrig_sustain");
        check("retrig_ticks", m_att_ticks[0], 5);
        key = 3'b000;
        n = 0;
        while (m_state[0] != 0 && n < 1000) begin @(negedge clock); n++; end
        if (n >= 1000) timed_out("release_to_idle");
        check("release_ticks", m_rel_ticks[0], 85);
        cycles(2);
        check("active0_off", int'(active[0]), 0);

        // Key release lands on the same cycle as a tick at level 40
        key = 3'b001;
        n = 0;
        while (!(m_state[0] == 1 && m_level[0] == 40) && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) timed_out("attack_to_40");
        cycles(1);
        key = 3'b000;
        cycles(3);
        check("simul_state", m_state[0], 3);
        check("simul_level", m_level[0], 40);
        cycles(4);
        check("simul_first_dec", m_level[0], 39);

        // Full mix, then a mid-period note change
        key  = 3'b111;
        note = 3'b111;
        n = 0;
        while (!(m_state[0] == 2 && m_state[1] == 2 && m_state[2] == 2) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) timed_out("all_sustain");
        cycles(600);
        n = 0;
        while ((m_cyc % Period) != 0 && n < 300) begin @(negedge clock); n++; end
        if (n >= 300) timed_out("period_align");
        count_high(100, 3'b101, h);
        check("boundary_old_period", h, 255);
        count_high(-1, note, h);
        check("mix101_high", h, 170);

        // Asynchronous reset mid-run with all keys held
        check("active_before_reset", int'(active), 7);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_active", int'(active), 0);
        key = 3'b000;
        cycles(2);
        reset_n = 1'b1;
        h = 0;
        repeat (1024) begin @(negedge clock); h += int'(pwm_out); end
        check("post_reset_silent", h, 0);

        // Randomized key/note traffic against the model
        for (int it = 0; it < 60; it++) begin
            key  = 3'($urandom);
            note = 3'($urandom);
            cycles($urandom_range(20, 400));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
